ibuf_ctrl: RTL and testbench

Pointer and occupancy controller for the decoded-instruction FIFO between decode and rename/dispatch. It takes the sparse decode valid vector and produces compacted per-lane write addresses and enables, so valid lanes land in consecutive tail slots. It issues DISPATCH_WIDTH read addresses from head and tracks occupancy. It also sequences flush recovery: the queue is emptied, then fetch is held off for a programmable number of cycles. The SRAM itself is outside this block.

---
 rtl/ibuf_ctrl.sv | 143 ++++++++++++++
 tb/tb_ibuf_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_ctrl.sv
// Pointer/occupancy controller for the decoded-instruction queue: compacts sparse
// decode lanes onto consecutive tail slots, pops dispatch groups from head, and sequences flush recovery.
module ibuf_ctrl #(
  parameter int QUEUE_DEPTH    = 32,
  parameter int QUEUE_LOG      = 5,
  parameter int FETCH_WIDTH    = 8,
  parameter int DISPATCH_WIDTH = 4,
  parameter int FLUSH_HOLD     = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]              decodedVector_i,
  output logic [FETCH_WIDTH-1:0]              we_o,
  output logic [FETCH_WIDTH*QUEUE_LOG-1:0]    wrAddr_o,
  output logic [DISPATCH_WIDTH*QUEUE_LOG-1:0] rdAddr_o,
  output logic                                instBufferReady_o,
  output logic                                dispatch_o,
  output logic                                stallFetch_o,
  output logic [QUEUE_LOG:0]                  instCount_o,
  output logic                                overflow_o
);

  localparam int CW     = QUEUE_LOG + 2;
  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'((FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0);
  localparam logic [QUEUE_LOG:0] STALL_LEVEL = (QUEUE_LOG+1)'(QUEUE_DEPTH - FETCH_WIDTH);
  localparam logic [QUEUE_LOG:0] DISP_LEVEL  = (QUEUE_LOG+1)'(DISPATCH_WIDTH);
  localparam logic [QUEUE_LOG:0] DEPTH_CNT   = (QUEUE_LOG+1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0]      DISP_STEP   = CW'(DISPATCH_WIDTH);
  localparam logic [CW-1:0]      DEPTH_CW    = CW'(QUEUE_DEPTH);

  typedef enum logic {RUN, HOLD} ibufStateT;

  ibufStateT             state, nextState;
  logic [HOLD_W-1:0]     holdCnt, nextHoldCnt;
  logic [QUEUE_LOG-1:0]  head, tail;
  logic [QUEUE_LOG:0]    count, nextCount;
  logic                  overflow;
  logic                  accept;
  logic [CW-1:0]         nWr, nRd, popTotal, running, sumCount;
  logic                  overflowHit;
  logic [QUEUE_LOG-1:0]  laneOffset [FETCH_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      holdCnt <= '0;
    end else begin
      state   <= nextState;
      holdCnt <= nextHoldCnt;
    end
  end

  // A flush always restarts the hold window, even when already holding.
  always_comb begin
    nextState   = state;
    nextHoldCnt = holdCnt;
    if (flush_i) begin
      if (FLUSH_HOLD > 0) begin
        nextState   = HOLD;
        nextHoldCnt = HOLD_RELOAD;
      end else begin
        nextState = RUN;
      end
    end else if (state == HOLD) begin
      if (holdCnt == '0) begin
        nextState = RUN;
      end else begin
        nextHoldCnt = holdCnt - HOLD_W'(1);
      end
    end
  end

  // Accept is gated by reset so no lane write escapes while the block is held in reset.
  always_comb begin
    stallFetch_o      = (state == HOLD) || (count > STALL_LEVEL);
    instBufferReady_o = (state == RUN) && (count >= DISP_LEVEL);
    accept            = reset && decodeReady_i && !stallFetch_o && !flush_i;
    dispatch_o        = instBufferReady_o && !stall_i && !flush_i;
    nRd               = dispatch_o ? DISP_STEP : '0;
    instCount_o       = count;
    overflow_o        = overflow;
  end

  // Lane j lands at tail plus the number of valid lanes below it.
  always_comb begin
    running = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      laneOffset[j] = running[QUEUE_LOG-1:0];
      running       = running + CW'(decodedVector_i[j]);
    end
    popTotal = running;
  end

  always_comb begin
    we_o     = '0;
    wrAddr_o = '0;
    nWr      = accept ? popTotal : '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      we_o[j]                             = accept && decodedVector_i[j];
      wrAddr_o[j*QUEUE_LOG +: QUEUE_LOG]  = tail + laneOffset[j];
    end
  end

  always_comb begin
    rdAddr_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      rdAddr_o[k*QUEUE_LOG +: QUEUE_LOG] = head + QUEUE_LOG'(k);
    end
  end

  // Occupancy is widened so an impossible overshoot is caught rather than wrapping.
  always_comb begin
    sumCount    = {1'b0, count} + nWr - nRd;
    overflowHit = sumCount > DEPTH_CW;
    nextCount   = overflowHit ? DEPTH_CNT : sumCount[QUEUE_LOG:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + nWr[QUEUE_LOG-1:0];
      head  <= head + nRd[QUEUE_LOG-1:0];
      count <= nextCount;
      if (overflowHit) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibuf_ctrl.sv
// Directed bench for ibuf_ctrl: a table of per-cycle vectors plus hand sequences
// for sparse compaction, flush/hold recovery and reset during hold.
module tb_ibuf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall;
  logic        decodeReady;
  logic [7:0]  decodedVector;
  logic [7:0]  we;
  logic [39:0] wrAddr;
  logic [19:0] rdAddr;
  logic        instBufferReady;
  logic        dispatch;
  logic        stallFetch;
  logic [5:0]  instCount;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       flush;
    logic       stall;
    logic       ready;
    logic [7:0] vec;
    logic [7:0] expWe;
    logic [4:0] expTail;
    logic [4:0] expHead;
    logic [5:0] expCount;
    logic       expDisp;
    logic       expRdy;
    logic       expStallF;
  } vecRecT;

  vecRecT tbl [16];

  ibuf_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush),
    .stall_i           (stall),
    .decodeReady_i     (decodeReady),
    .decodedVector_i   (decodedVector),
    .we_o              (we),
    .wrAddr_o          (wrAddr),
    .rdAddr_o          (rdAddr),
    .instBufferReady_o (instBufferReady),
    .dispatch_o        (dispatch),
    .stallFetch_o      (stallFetch),
    .instCount_o       (instCount),
    .overflow_o        (overflow)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [39:0] wrModel(input logic [4:0] t, input logic [7:0] v);
    logic [39:0] r;
    logic [4:0]  a;
    r = '0;
    a = t;
    for (int j = 0; j < 8; j++) begin
      r[j*5 +: 5] = a;
      a = a + 5'(v[j]);
    end
    return r;
  endfunction

  function automatic logic [19:0] rdModel(input logic [4:0] h);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*5 +: 5] = h + 5'(k);
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic f, input logic s, input logic r, input logic [7:0] v);
    flush         = f;
    stall         = s;
    decodeReady   = r;
    decodedVector = v;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 5'd0,  5'd0,  6'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd8,  5'd0,  6'd8,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 5'd8,  5'd0,  6'd8,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F, 5'd12, 5'd4,  6'd8,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 5'd16, 5'd4,  6'd12, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h1F, 8'h1F, 5'd24, 5'd4,  6'd20, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 5'd29, 5'd4,  6'd25, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 5'd29, 5'd4,  6'd25, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd29, 5'd8,  6'd21, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h81, 8'h81, 5'd29, 5'd12, 6'd17, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 5'd31, 5'd16, 6'd15, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd7,  5'd20, 6'd19, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd7,  5'd24, 6'd15, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd7,  5'd28, 6'd11, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd7,  5'd0,  6'd7,  1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd7,  5'd4,  6'd3,  1'b0, 1'b0, 1'b0};

    // Reset state, with a full decode bundle offered that must be ignored.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    #3;
    checkOutput("rst we", 64'(we), 64'h0);
    checkOutput("rst dispatch", 64'(dispatch), 64'h0);
    checkOutput("rst ready", 64'(instBufferReady), 64'h0);
    checkOutput("rst stallFetch", 64'(stallFetch), 64'h0);
    checkOutput("rst count", 64'(instCount), 64'h0);
    checkOutput("rst rdAddr", 64'(rdAddr), 64'(rdModel(5'd0)));
    checkOutput("rst overflow", 64'(overflow), 64'h0);
    stepCycle();
    stepCycle();
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].flush, tbl[i].stall, tbl[i].ready, tbl[i].vec);
      @(negedge clk);
      checkOutput($sformatf("row%0d we", i), 64'(we), 64'(tbl[i].expWe));
      checkOutput($sformatf("row%0d wrAddr", i), 64'(wrAddr), 64'(wrModel(tbl[i].expTail, tbl[i].vec)));
      checkOutput($sformatf("row%0d rdAddr", i), 64'(rdAddr), 64'(rdModel(tbl[i].expHead)));
      checkOutput($sformatf("row%0d count", i), 64'(instCount), 64'(tbl[i].expCount));
      checkOutput($sformatf("row%0d dispatch", i), 64'(dispatch), 64'(tbl[i].expDisp));
      checkOutput($sformatf("row%0d ready", i), 64'(instBufferReady), 64'(tbl[i].expRdy));
      checkOutput($sformatf("row%0d stallFetch", i), 64'(stallFetch), 64'(tbl[i].expStallF));
      checkOutput($sformatf("row%0d overflow", i), 64'(overflow), 64'h0);
      stepCycle();
    end

    // Sparse compaction starting at tail 3.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h07);
    @(negedge clk);
    checkOutput("seqA we07", 64'(we), 64'h07);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
    @(negedge clk);
    checkOutput("seqA weA5", 64'(we), 64'hA5);
    checkOutput("seqA count3", 64'(instCount), 64'd3);
    checkOutput("seqA lane0", 64'(wrAddr[4:0]), 64'd3);
    checkOutput("seqA lane2", 64'(wrAddr[14:10]), 64'd4);
    checkOutput("seqA lane5", 64'(wrAddr[29:25]), 64'd5);
    checkOutput("seqA lane7", 64'(wrAddr[39:35]), 64'd6);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("seqA count7", 64'(instCount), 64'd7);
    checkOutput("seqA tail7", 64'(wrAddr[4:0]), 64'd7);
    stepCycle();

    // Flush with occupancy 12 plus same-cycle write and pop request.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0F);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    checkOutput("flush count12", 64'(instCount), 64'd12);
    checkOutput("flush we", 64'(we), 64'h0);
    checkOutput("flush dispatch", 64'(dispatch), 64'h0);
    checkOutput("flush ready", 64'(instBufferReady), 64'h1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    checkOutput("hold1 stallFetch", 64'(stallFetch), 64'h1);
    checkOutput("hold1 we", 64'(we), 64'h0);
    checkOutput("hold1 count", 64'(instCount), 64'h0);
    checkOutput("hold1 rdAddr", 64'(rdAddr), 64'(rdModel(5'd0)));
    checkOutput("hold1 wrAddr", 64'(wrAddr), 64'(wrModel(5'd0, 8'hFF)));
    stepCycle();
    @(negedge clk);
    checkOutput("hold2 stallFetch", 64'(stallFetch), 64'h1);
    checkOutput("hold2 we", 64'(we), 64'h0);
    checkOutput("hold2 count", 64'(instCount), 64'h0);
    stepCycle();
    @(negedge clk);
    checkOutput("run stallFetch", 64'(stallFetch), 64'h0);
    checkOutput("run we", 64'(we), 64'hFF);
    stepCycle();

    // Reset asserted while holding after a second flush.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("seqC count8", 64'(instCount), 64'd8);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    #1;
    checkOutput("seqC inHold", 64'(stallFetch), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("seqC rst stallFetch", 64'(stallFetch), 64'h0);
    checkOutput("seqC rst we", 64'(we), 64'h0);
    checkOutput("seqC rst count", 64'(instCount), 64'h0);
    checkOutput("seqC rst dispatch", 64'(dispatch), 64'h0);
    checkOutput("seqC rst ready", 64'(instBufferReady), 64'h0);
    checkOutput("seqC rst rdAddr", 64'(rdAddr), 64'(rdModel(5'd0)));
    stepCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("seqC run stallFetch", 64'(stallFetch), 64'h0);
    checkOutput("seqC run we", 64'(we), 64'hFF);
    checkOutput("seqC run wrAddr", 64'(wrAddr), 64'(wrModel(5'd0, 8'hFF)));
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("seqC count8b", 64'(instCount), 64'd8);
    checkOutput("final overflow", 64'(overflow), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
